// File: rtl/aximm_csr_responder.sv
// +------------------------------------------------------------------------+
// | aximm_csr_responder: edge-triggered CSR block for the pattern engine.   |
// | Option: AXIMM_CSR_DECERR_CNT_EN adds the unmapped-access counter.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module aximm_csr_responder #(
  parameter logic [31:0] DLY_X_RST = 32'h0000000C,
  parameter logic [31:0] DLY_Y_RST = 32'h00000020,
  parameter logic [31:0] DLY_Z_RST = 32'h00001770
) (
  input  logic        ms_wr_clk,
  input  logic        i_w_m_wr_rst_n,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wrdata,
  input  logic        i_wren,
  input  logic        i_rden,
  output logic [31:0] o_master_readdata,
  output logic        o_master_readdatavalid,
  output logic        o_master_waitrequest,
  input  logic [3:0]  i_linkup_sts,
  input  logic [3:0]  i_bus_sts,
  input  logic        i_wr_done,
  input  logic        i_rd_done,
  input  logic [63:0] i_dout_first,
  input  logic [63:0] i_dout_last,
  input  logic [63:0] i_din_first,
  input  logic [63:0] i_din_last,
  output logic [31:0] o_wr_cfg,
  output logic [31:0] o_rd_cfg,
  output logic [31:0] o_wr_rd_addr,
  output logic [31:0] o_dly_x,
  output logic [31:0] o_dly_y,
  output logic [31:0] o_dly_z,
  output logic        o_wr_start,
  output logic        o_rd_start
);

  localparam logic [31:0] c_ADDR_WR_CFG     = 32'h50001000;
  localparam logic [31:0] c_ADDR_WR_RD_ADDR = 32'h50001004;
  localparam logic [31:0] c_ADDR_BUS_STS    = 32'h50001008;
  localparam logic [31:0] c_ADDR_LINKUP     = 32'h5000100C;
  localparam logic [31:0] c_ADDR_RD_CFG     = 32'h50001010;
  localparam logic [31:0] c_ADDR_DECERR     = 32'h50001018;
  localparam logic [31:0] c_ADDR_DLY_X      = 32'h50002000;
  localparam logic [31:0] c_ADDR_DLY_Y      = 32'h50002004;
  localparam logic [31:0] c_ADDR_DLY_Z      = 32'h50002008;
  localparam logic [31:0] c_ADDR_DOUT_F_LO  = 32'h50004000;
  localparam logic [31:0] c_ADDR_DOUT_F_HI  = 32'h50004004;
  localparam logic [31:0] c_ADDR_DOUT_L_LO  = 32'h50004010;
  localparam logic [31:0] c_ADDR_DOUT_L_HI  = 32'h50004014;
  localparam logic [31:0] c_ADDR_DIN_F_LO   = 32'h50004020;
  localparam logic [31:0] c_ADDR_DIN_F_HI   = 32'h50004024;
  localparam logic [31:0] c_ADDR_DIN_L_LO   = 32'h50004030;
  localparam logic [31:0] c_ADDR_DIN_L_HI   = 32'h50004034;

  logic        wren_q, rden_q, init_q;
  logic [31:0] wr_cfg_q, rd_cfg_q, wr_rd_addr_q;
  logic [31:0] dly_x_q, dly_y_q, dly_z_q;
  logic        wr_sticky_q, rd_sticky_q;
  logic        wr_start_q, rd_start_q;
  logic        wr_busy_q, rd_pend_q, rvalid_q;
  logic [31:0] rd_addr_q, rdata_q;
  logic [31:0] rdata_d;
  logic        w_wr_edge, w_rd_edge;

  // init_q masks the first cycle after reset so a level already high is not an edge
  assign w_wr_edge = init_q & i_wren & ~wren_q;
  assign w_rd_edge = init_q & i_rden & ~rden_q & ~w_wr_edge;

  always_ff @(posedge ms_wr_clk) begin
    if (!i_w_m_wr_rst_n) begin
      wren_q <= 1'b0;
      rden_q <= 1'b0;
      init_q <= 1'b0;
    end else begin
      wren_q <= i_wren;
      rden_q <= i_rden;
      init_q <= 1'b1;
    end
  end

  always_ff @(posedge ms_wr_clk) begin
    if (!i_w_m_wr_rst_n) begin
      wr_cfg_q     <= '0;
      rd_cfg_q     <= '0;
      wr_rd_addr_q <= '0;
      dly_x_q      <= DLY_X_RST;
      dly_y_q      <= DLY_Y_RST;
      dly_z_q      <= DLY_Z_RST;
      wr_start_q   <= 1'b0;
      rd_start_q   <= 1'b0;
      wr_busy_q    <= 1'b0;
    end else begin
      wr_start_q <= w_wr_edge && (i_wr_addr == c_ADDR_WR_CFG);
      rd_start_q <= w_wr_edge && (i_wr_addr == c_ADDR_RD_CFG);
      wr_busy_q  <= w_wr_edge;
      if (w_wr_edge) begin
        case (i_wr_addr)
          c_ADDR_WR_CFG:     wr_cfg_q     <= i_wrdata;
          c_ADDR_WR_RD_ADDR: wr_rd_addr_q <= i_wrdata;
          c_ADDR_RD_CFG:     rd_cfg_q     <= i_wrdata;
          c_ADDR_DLY_X:      dly_x_q      <= i_wrdata;
          c_ADDR_DLY_Y:      dly_y_q      <= i_wrdata;
          c_ADDR_DLY_Z:      dly_z_q      <= i_wrdata;
          default: ;
        endcase
      end
    end
  end

  // Start pulse clears the sticky even if a done pulse lands in the same cycle
  always_ff @(posedge ms_wr_clk) begin
    if (!i_w_m_wr_rst_n) begin
      wr_sticky_q <= 1'b0;
      rd_sticky_q <= 1'b0;
    end else begin
      if (wr_start_q)     wr_sticky_q <= 1'b0;
      else if (i_wr_done) wr_sticky_q <= 1'b1;
      if (rd_start_q)     rd_sticky_q <= 1'b0;
      else if (i_rd_done) rd_sticky_q <= 1'b1;
    end
  end

`ifdef AXIMM_CSR_DECERR_CNT_EN
  logic [7:0] decerr_q;
  logic       w_mapped;

  always_comb begin
    w_mapped = 1'b0;
    case (i_wr_addr)
      c_ADDR_WR_CFG, c_ADDR_WR_RD_ADDR, c_ADDR_BUS_STS, c_ADDR_LINKUP,
      c_ADDR_RD_CFG, c_ADDR_DECERR, c_ADDR_DLY_X, c_ADDR_DLY_Y, c_ADDR_DLY_Z,
      c_ADDR_DOUT_F_LO, c_ADDR_DOUT_F_HI, c_ADDR_DOUT_L_LO, c_ADDR_DOUT_L_HI,
      c_ADDR_DIN_F_LO, c_ADDR_DIN_F_HI, c_ADDR_DIN_L_LO, c_ADDR_DIN_L_HI:
        w_mapped = 1'b1;
      default: w_mapped = 1'b0;
    endcase
  end

  always_ff @(posedge ms_wr_clk) begin
    if (!i_w_m_wr_rst_n)
      decerr_q <= '0;
    else if (w_wr_edge && (i_wr_addr == c_ADDR_DECERR))
      decerr_q <= '0;
    else if ((w_wr_edge || w_rd_edge) && !w_mapped && (decerr_q != 8'hFF))
      decerr_q <= decerr_q + 8'd1;
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (rd_addr_q)
      c_ADDR_WR_CFG:     rdata_d = wr_cfg_q;
      c_ADDR_WR_RD_ADDR: rdata_d = wr_rd_addr_q;
      c_ADDR_BUS_STS:    rdata_d = {26'b0, rd_sticky_q, wr_sticky_q, i_bus_sts};
      c_ADDR_LINKUP:     rdata_d = {28'b0, i_linkup_sts};
      c_ADDR_RD_CFG:     rdata_d = rd_cfg_q;
      c_ADDR_DLY_X:      rdata_d = dly_x_q;
      c_ADDR_DLY_Y:      rdata_d = dly_y_q;
      c_ADDR_DLY_Z:      rdata_d = dly_z_q;
      c_ADDR_DOUT_F_LO:  rdata_d = i_dout_first[31:0];
      c_ADDR_DOUT_F_HI:  rdata_d = i_dout_first[63:32];
      c_ADDR_DOUT_L_LO:  rdata_d = i_dout_last[31:0];
      c_ADDR_DOUT_L_HI:  rdata_d = i_dout_last[63:32];
      c_ADDR_DIN_F_LO:   rdata_d = i_din_first[31:0];
      c_ADDR_DIN_F_HI:   rdata_d = i_din_first[63:32];
      c_ADDR_DIN_L_LO:   rdata_d = i_din_last[31:0];
      c_ADDR_DIN_L_HI:   rdata_d = i_din_last[63:32];
`ifdef AXIMM_CSR_DECERR_CNT_EN
      c_ADDR_DECERR:     rdata_d = {24'b0, decerr_q};
`endif
      default:           rdata_d = '0;
    endcase
  end

  // Read pipeline: address captured after the edge, data presented one cycle later
  always_ff @(posedge ms_wr_clk) begin
    if (!i_w_m_wr_rst_n) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rd_pend_q <= w_rd_edge;
      if (w_rd_edge) rd_addr_q <= i_wr_addr;
      rvalid_q  <= rd_pend_q;
      if (rd_pend_q) rdata_q <= rdata_d;
    end
  end

  assign o_master_readdata      = rdata_q;
  assign o_master_readdatavalid = rvalid_q;
  assign o_master_waitrequest   = wr_busy_q | rd_pend_q | rvalid_q;
  assign o_wr_cfg               = wr_cfg_q;
  assign o_rd_cfg               = rd_cfg_q;
  assign o_wr_rd_addr           = wr_rd_addr_q;
  assign o_dly_x                = dly_x_q;
  assign o_dly_y                = dly_y_q;
  assign o_dly_z                = dly_z_q;
  assign o_wr_start             = wr_start_q;
  assign o_rd_start             = rd_start_q;

endmodule

`default_nettype wire

// File: tb/tb_aximm_csr_responder.sv
// +------------------------------------------------------------------------+
// | tb_aximm_csr_responder: scoreboard bench for the CSR responder.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_aximm_csr_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_wr_addr = '0;
  logic [31:0] i_wrdata = '0;
  logic        i_wren = 1'b0;
  logic        i_rden = 1'b0;
  logic [31:0] o_master_readdata;
  logic        o_master_readdatavalid;
  logic        o_master_waitrequest;
  logic [3:0]  i_linkup_sts = 4'h9;
  logic [3:0]  i_bus_sts = 4'hF;
  logic        i_wr_done = 1'b0;
  logic        i_rd_done = 1'b0;
  logic [63:0] i_dout_first = 64'hFEDCBA98_76543210;
  logic [63:0] i_dout_last = 64'h0;
  logic [63:0] i_din_first = 64'h0;
  logic [63:0] i_din_last = 64'h01234567_89ABCDEF;
  logic [31:0] o_wr_cfg, o_rd_cfg, o_wr_rd_addr, o_dly_x, o_dly_y, o_dly_z;
  logic        o_wr_start, o_rd_start;

  aximm_csr_responder dut (
    .ms_wr_clk              (clk),
    .i_w_m_wr_rst_n         (rst_n),
    .i_wr_addr              (i_wr_addr),
    .i_wrdata               (i_wrdata),
    .i_wren                 (i_wren),
    .i_rden                 (i_rden),
    .o_master_readdata      (o_master_readdata),
    .o_master_readdatavalid (o_master_readdatavalid),
    .o_master_waitrequest   (o_master_waitrequest),
    .i_linkup_sts           (i_linkup_sts),
    .i_bus_sts              (i_bus_sts),
    .i_wr_done              (i_wr_done),
    .i_rd_done              (i_rd_done),
    .i_dout_first           (i_dout_first),
    .i_dout_last            (i_dout_last),
    .i_din_first            (i_din_first),
    .i_din_last             (i_din_last),
    .o_wr_cfg               (o_wr_cfg),
    .o_rd_cfg               (o_rd_cfg),
    .o_wr_rd_addr           (o_wr_rd_addr),
    .o_dly_x                (o_dly_x),
    .o_dly_y                (o_dly_y),
    .o_dly_z                (o_dly_z),
    .o_wr_start             (o_wr_start),
    .o_rd_start             (o_rd_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   wr_start_cnt = 0;
  int   rd_start_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every readdatavalid must match the oldest expected read, on time
  always @(negedge clk) begin
    exp_t e;
    if (o_wr_start) wr_start_cnt++;
    if (o_rd_start) rd_start_cnt++;
    if (o_master_readdatavalid) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid got=%h required=no_valid cyc=%0d", o_master_readdata, cyc);
      end else begin
        e = sb_q.pop_front();
        if (o_master_readdata !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL read_data got=%h@%0d required=%h@%0d", o_master_readdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int hold);
    @(posedge clk); #1;
    i_wr_addr = addr;
    i_wrdata  = data;
    i_wren    = 1'b1;
    repeat (hold - 1) @(posedge clk);
    @(posedge clk); #1;
    i_wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    @(posedge clk); #1;
    i_wr_addr = addr;
    i_rden    = 1'b1;
    e.data = exp;
    e.cyc  = cyc + 2;
    sb_q.push_back(e);
    @(posedge clk); #1;
    i_rden = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    exp_t e;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    chk("rst_wr_cfg", o_wr_cfg, 32'h0);
    chk("rst_rd_cfg", o_rd_cfg, 32'h0);
    chk("rst_dly_x", o_dly_x, 32'h0000000C);
    chk("rst_dly_y", o_dly_y, 32'h00000020);
    chk("rst_dly_z", o_dly_z, 32'h00001770);
    chk("rst_readdata", o_master_readdata, 32'h0);
    chk("rst_waitreq", {31'b0, o_master_waitrequest}, 32'h0);

    rd(32'h50002008, 32'h00001770);
    idle(3);

    s0 = wr_start_cnt;
    wr(32'h50001000, 32'h00041804, 3);
    idle(3);
    chk("wr_cfg_held", o_wr_cfg, 32'h00041804);
    chk("wr_start_once", wr_start_cnt - s0, 1);

    // Waitrequest spans the two cycles after a read edge
    @(posedge clk); #1;
    i_wr_addr = 32'h50002004;
    i_rden = 1'b1;
    e.data = 32'h00000020;
    e.cyc  = cyc + 2;
    sb_q.push_back(e);
    @(posedge clk); #1;
    i_rden = 1'b0;
    @(negedge clk);
    chk("waitreq_n1", {31'b0, o_master_waitrequest}, 32'h1);
    @(negedge clk);
    chk("waitreq_n2", {31'b0, o_master_waitrequest}, 32'h1);
    @(negedge clk);
    chk("waitreq_n3", {31'b0, o_master_waitrequest}, 32'h0);
    idle(2);

    @(posedge clk); #1; i_wr_done = 1'b1;
    @(posedge clk); #1; i_wr_done = 1'b0;
    rd(32'h50001008, 32'h0000001F);
    wr(32'h50001000, 32'h00000001, 1);
    idle(2);
    rd(32'h50001008, 32'h0000000F);
    @(posedge clk); #1; i_rd_done = 1'b1;
    @(posedge clk); #1; i_rd_done = 1'b0;
    rd(32'h50001008, 32'h0000002F);
    s0 = rd_start_cnt;
    wr(32'h50001010, 32'h00000005, 1);
    idle(2);
    chk("rd_cfg", o_rd_cfg, 32'h00000005);
    chk("rd_start_once", rd_start_cnt - s0, 1);
    rd(32'h50001008, 32'h0000000F);

    rd(32'h50004030, 32'h89ABCDEF);
    rd(32'h50004034, 32'h01234567);
    rd(32'h50004000, 32'h76543210);
    rd(32'h50004004, 32'hFEDCBA98);
    rd(32'h5000100C, 32'h00000009);
    wr(32'h50002000, 32'hDEADBEEF, 1);
    rd(32'h50002000, 32'hDEADBEEF);
    rd(32'h50005000, 32'h00000000);
    idle(4);

    // Simultaneous edges: write wins, read must vanish
    @(posedge clk); #1;
    i_wr_addr = 32'h50001004;
    i_wrdata  = 32'h11223344;
    i_wren = 1'b1;
    i_rden = 1'b1;
    @(posedge clk); #1;
    i_wren = 1'b0;
    i_rden = 1'b0;
    idle(4);
    chk("wr_rd_addr_simul", o_wr_rd_addr, 32'h11223344);
    rd(32'h50001004, 32'h11223344);
    idle(4);

    // Reset during N+1 of a read, with i_wren held high across release
    s0 = wr_start_cnt;
    @(posedge clk); #1;
    i_wr_addr = 32'h50002000;
    i_rden = 1'b1;
    @(posedge clk); #1;
    i_rden = 1'b0;
    rst_n = 1'b0;
    i_wr_addr = 32'h50001000;
    i_wrdata = 32'hA5A5A5A5;
    i_wren = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("held_wren_no_write", o_wr_cfg, 32'h0);
    chk("held_wren_no_start", wr_start_cnt - s0, 0);
    chk("rst2_dly_x", o_dly_x, 32'h0000000C);
    chk("rst2_wr_rd_addr", o_wr_rd_addr, 32'h0);
    i_wren = 1'b0;
    idle(2);

    for (int i = 0; i < 300; i++) wr(32'h50003000, 32'h0, 1);
`ifdef AXIMM_CSR_DECERR_CNT_EN
    rd(32'h50001018, 32'h000000FF);
    idle(3);
    wr(32'h50001018, 32'h0, 1);
    rd(32'h50001018, 32'h00000000);
`else
    rd(32'h50001018, 32'h00000000);
`endif
    idle(6);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL missing_rvalid got=%0d_pending required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
